// File: rtl/rgmii_tx_arbiter.sv
// Two-source, frame-granular round-robin arbiter feeding the RGMII MAC TX AXI-stream
// port. It enforces an idle gap between frames and truncates frames that run past MAX_LEN.
module rgmii_tx_arbiter #(
    parameter int IFG_CYCLES = 12,
    parameter int MAX_LEN    = 1518
) (
    input  logic        clk_int,
    input  logic        rst_int,
    input  logic [7:0]  s0_tdata,
    input  logic        s0_tvalid,
    input  logic        s0_tlast,
    input  logic        s0_tuser,
    output logic        s0_tready,
    input  logic [7:0]  s1_tdata,
    input  logic        s1_tvalid,
    input  logic        s1_tlast,
    input  logic        s1_tuser,
    output logic        s1_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        m_tuser,
    input  logic        m_tready,
    output logic [1:0]  grant,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1,
    output logic [15:0] trunc_cnt
);
    typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;

    localparam logic [15:0] BEAT_LAST = 16'(MAX_LEN - 1);
    localparam logic [15:0] IFG_LAST  = 16'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam bit          NO_GAP    = (IFG_CYCLES == 0);

    state_t      state;
    logic        last_s1;
    logic [15:0] beat_cnt;
    logic [15:0] ifg_cnt;
    logic [7:0]  sel_data;
    logic        sel_valid;
    logic        sel_last;
    logic        sel_user;
    logic        at_limit;
    logic        m_hs;
    logic        frame_done;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign sel_data   = grant[1] ? s1_tdata  : s0_tdata;
    assign sel_valid  = grant[1] ? s1_tvalid : s0_tvalid;
    assign sel_last   = grant[1] ? s1_tlast  : s0_tlast;
    assign sel_user   = grant[1] ? s1_tuser  : s0_tuser;
    assign at_limit   = (beat_cnt == BEAT_LAST);
    assign m_hs       = (state == SEND) && sel_valid && m_tready;
    // A frame ends on a genuine source tlast, whether forwarded or being drained.
    assign frame_done = (m_hs && sel_last) || ((state == DRAIN) && sel_valid && sel_last);

    always_comb begin
        m_tdata   = 8'h00;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        m_tuser   = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state)
            SEND: begin
                m_tdata   = sel_data;
                m_tvalid  = sel_valid;
                m_tlast   = sel_last | at_limit;
                m_tuser   = sel_user | (at_limit & ~sel_last);
                s0_tready = grant[0] & m_tready;
                s1_tready = grant[1] & m_tready;
            end
            DRAIN: begin
                s0_tready = grant[0];
                s1_tready = grant[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_s1    <= 1'b1;
            beat_cnt   <= 16'd0;
            ifg_cnt    <= 16'd0;
            frame_cnt0 <= 16'd0;
            frame_cnt1 <= 16'd0;
            trunc_cnt  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_tvalid && (!s1_tvalid || last_s1)) begin
                        grant <= 2'b01;
                        state <= SEND;
                    end else if (s1_tvalid) begin
                        grant <= 2'b10;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (m_hs) begin
                        beat_cnt <= beat_cnt + 16'd1;
                        if (sel_last) begin
                            last_s1 <= grant[1];
                            if (grant[0]) frame_cnt0 <= sat_inc(frame_cnt0);
                            else          frame_cnt1 <= sat_inc(frame_cnt1);
                        end else if (at_limit) begin
                            last_s1   <= grant[1];
                            trunc_cnt <= sat_inc(trunc_cnt);
                            state     <= DRAIN;
                        end
                    end
                end
                GAP: begin
                    if (ifg_cnt == IFG_LAST) begin
                        state    <= IDLE;
                        grant    <= 2'b00;
                        beat_cnt <= 16'd0;
                    end else begin
                        ifg_cnt <= ifg_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
            if (frame_done) begin
                ifg_cnt <= 16'd0;
                if (NO_GAP) begin
                    state    <= IDLE;
                    grant    <= 2'b00;
                    beat_cnt <= 16'd0;
                end else begin
                    state <= GAP;
                end
            end
        end
    end
endmodule
